// File: rtl/bus_sync_pkg.sv
// Shared types and defaults for the bus_sync_rx receiver and its synchronizer.
package bus_sync_pkg;

  // Default depth of the REQ synchronizer chain; two flops is the minimum.
  localparam int NUM_STAGES_DEFAULT = 2;

  // Default data bus width in bits.
  localparam int BUS_WIDTH_DEFAULT = 8;

  // Receiver FSM: waiting for a new request, or holding a word for the consumer.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer into the CLK domain.
// The chain is cleared asynchronously by RST (active-low). NUM_STAGES must be >= 2.
module bit_sync
  import bus_sync_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic unsync,
  output logic synced
);

  logic [NUM_STAGES-1:0] chain_reg;

  // Shift the asynchronous level through the flop chain; bit 0 is the metastable-exposed stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[NUM_STAGES-2:0], unsync};
    end
  end

  assign synced = chain_reg[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_rx.sv
// Toggle-handshake bus receiver: captures UNSYNC_BUS when the synchronized REQ
// level differs from the level of the last captured word, presents it with
// VALID until RDY, then returns an ACK toggle to the source.
// RST is asynchronous active-low; its release is expected to be synchronized to CLK upstream.
// Optional feature: define BUS_SYNC_RX_PARITY_EN to add UNSYNC_PAR / PAR_ERR even-parity checking.
module bus_sync_rx
  import bus_sync_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UNSYNC_REQ,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
`ifdef BUS_SYNC_RX_PARITY_EN
  input  logic                 UNSYNC_PAR,
  output logic                 PAR_ERR,
`endif
  input  logic                 RDY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 VALID,
  output logic                 ENABLE_PULSE,
  output logic                 ACK
);

  state_t               state_reg;
  logic                 req_s;
  logic                 req_seen_reg;
  logic [BUS_WIDTH-1:0] sync_bus_reg;
  logic                 valid_reg;
  logic                 enable_pulse_reg;
  logic                 ack_reg;
  logic                 capture;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_req_sync (
    .CLK   (CLK),
    .RST   (RST),
    .unsync(UNSYNC_REQ),
    .synced(req_s)
  );

  // A new word is taken only from IDLE; toggles arriving during HOLD stay visible on req_s.
  assign capture = (state_reg == IDLE) && (req_s != req_seen_reg);

  // Handshake FSM with registered data, strobe and acknowledge outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg        <= IDLE;
      req_seen_reg     <= 1'b0;
      sync_bus_reg     <= '0;
      valid_reg        <= 1'b0;
      enable_pulse_reg <= 1'b0;
      ack_reg          <= 1'b0;
    end else begin
      enable_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (capture) begin
            sync_bus_reg     <= UNSYNC_BUS;
            req_seen_reg     <= req_s;
            valid_reg        <= 1'b1;
            enable_pulse_reg <= 1'b1;
            state_reg        <= HOLD;
          end
        end
        HOLD: begin
          if (RDY) begin
            valid_reg <= 1'b0;
            ack_reg   <= ~ack_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BUS_SYNC_RX_PARITY_EN
  logic par_err_reg;

  // Even parity: the parity bit equals the XOR of the data bits; flag a mismatch at capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_reg <= 1'b0;
    end else if (capture) begin
      par_err_reg <= (^UNSYNC_BUS) ^ UNSYNC_PAR;
    end
  end

  assign PAR_ERR = par_err_reg;
`else
  // Parity checking is not built in this configuration.
`endif

  assign SYNC_BUS     = sync_bus_reg;
  assign VALID        = valid_reg;
  assign ENABLE_PULSE = enable_pulse_reg;
  assign ACK          = ack_reg;

endmodule
